// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// MEM pipeline stage. Issues data-memory loads/stores over a variable-latency
// req/ack bus and freezes the upstream pipeline until each access completes.
// Non-memory instructions pass straight through to MEM/WB with zero latency.
// A wait counter aborts an access whose ack never arrives.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   WB_EN           EXE/MEM writeback enable
//   MEM_R_EN        EXE/MEM load
//   MEM_W_EN        EXE/MEM store (wins over load when both are set)
//   ALURes          EXE/MEM effective address / ALU result
//   STVal           EXE/MEM store data
//   dest            EXE/MEM destination register
//   freeze          combinational stall to PC, IF/ID, ID/EXE, EXE/MEM
//   mem_req         bus request (registered)
//   mem_we          bus write strobe (registered)
//   mem_addr        bus address (registered)
//   mem_wdata       bus write data (registered)
//   mem_ack         bus completion pulse
//   mem_rdata       bus read data, valid with mem_ack
//   WB_EN_OUT       MEM/WB writeback enable, bubbled while frozen
//   MEM_R_EN_OUT    MEM/WB load select, bubbled while frozen
//   ALUResOut       MEM/WB ALU result passthrough
//   memReadVal      MEM/WB load data (registered)
//   destOut         MEM/WB destination passthrough
//   mem_err         sticky error: timeout or simultaneous read+write
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int unsigned WORD_LEN     = 16,
    parameter int unsigned REG_ADDR_LEN = 4,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    WB_EN,
    input  logic                    MEM_R_EN,
    input  logic                    MEM_W_EN,
    input  logic [WORD_LEN-1:0]     ALURes,
    input  logic [WORD_LEN-1:0]     STVal,
    input  logic [REG_ADDR_LEN-1:0] dest,
    output logic                    freeze,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [WORD_LEN-1:0]     mem_addr,
    output logic [WORD_LEN-1:0]     mem_wdata,
    input  logic                    mem_ack,
    input  logic [WORD_LEN-1:0]     mem_rdata,
    output logic                    WB_EN_OUT,
    output logic                    MEM_R_EN_OUT,
    output logic [WORD_LEN-1:0]     ALUResOut,
    output logic [WORD_LEN-1:0]     memReadVal,
    output logic [REG_ADDR_LEN-1:0] destOut,
    output logic                    mem_err
);

    // Counter wide enough for the largest supported TIMEOUT (255).
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [WORD_LEN-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_LEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [WORD_LEN-1:0] rd_val_q, rd_val_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic access_c;

    assign access_c = MEM_R_EN | MEM_W_EN;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_val_q    <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_val_q    <= rd_val_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_val_d    = rd_val_q;
        cnt_d       = cnt_q;
        err_d       = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (access_c) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = MEM_W_EN;
                    mem_addr_d  = ALURes;
                    mem_wdata_d = STVal;
                    cnt_d       = '0;
                    if (MEM_R_EN && MEM_W_EN) begin
                        err_d = 1'b1;
                    end
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // An ack on the final wait cycle takes priority over the abort.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rd_val_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    rd_val_d  = '0;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // Inputs still describe the completed instruction; ignore them.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stall while an access is being launched or is outstanding.
    assign freeze = ((state_q == S_IDLE) && access_c) || (state_q == S_WAIT);

    // Bubbles enter MEM/WB while stalled.
    assign WB_EN_OUT    = WB_EN & ~freeze;
    assign MEM_R_EN_OUT = MEM_R_EN & ~freeze;
    assign ALUResOut    = ALURes;
    assign destOut      = dest;

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign memReadVal = rd_val_q;
    assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int unsigned W       = 16;
    localparam int unsigned RW      = 4;
    localparam int          TIMEOUT = 15;

    logic          clk;
    logic          rst;
    logic          WB_EN, MEM_R_EN, MEM_W_EN;
    logic [W-1:0]  ALURes, STVal;
    logic [RW-1:0] dest;
    logic          freeze, mem_req, mem_we;
    logic [W-1:0]  mem_addr, mem_wdata;
    logic          mem_ack;
    logic [W-1:0]  mem_rdata;
    logic          WB_EN_OUT, MEM_R_EN_OUT;
    logic [W-1:0]  ALUResOut, memReadVal;
    logic [RW-1:0] destOut;
    logic          mem_err;

    mem_access_stage #(
        .WORD_LEN    (W),
        .REG_ADDR_LEN(RW),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .WB_EN       (WB_EN),
        .MEM_R_EN    (MEM_R_EN),
        .MEM_W_EN    (MEM_W_EN),
        .ALURes      (ALURes),
        .STVal       (STVal),
        .dest        (dest),
        .freeze      (freeze),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .WB_EN_OUT   (WB_EN_OUT),
        .MEM_R_EN_OUT(MEM_R_EN_OUT),
        .ALUResOut   (ALUResOut),
        .memReadVal  (memReadVal),
        .destOut     (destOut),
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] rval;
        logic         err;
        int           waits;
        logic         wb;
        logic         rout;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_rval = '0;
    logic         m_err  = 1'b0;

    logic prev_req = 1'b0;
    int   frz_cnt  = 0;
    int   req_cnt  = 0;

    // Completion monitor: pops the scoreboard in the DONE cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            prev_req = 1'b0;
            frz_cnt  = 0;
            req_cnt  = 0;
        end else begin
            if (freeze) begin
                frz_cnt++;
                checks++;
                if (WB_EN_OUT !== 1'b0 || MEM_R_EN_OUT !== 1'b0) begin
                    errors++;
                    $display("FAIL bubble: WB_EN_OUT=%b MEM_R_EN_OUT=%b expected 0/0 while frozen",
                             WB_EN_OUT, MEM_R_EN_OUT);
                end
            end
            if (mem_req) req_cnt++;
            if (prev_req && !mem_req) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty: access completed with no expectation queued");
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if (memReadVal !== e.rval) begin
                        errors++;
                        $display("FAIL done_rval: got %h expected %h", memReadVal, e.rval);
                    end
                    checks++;
                    if (mem_err !== e.err) begin
                        errors++;
                        $display("FAIL done_err: got %b expected %b", mem_err, e.err);
                    end
                    checks++;
                    if (mem_we !== e.we || mem_addr !== e.addr) begin
                        errors++;
                        $display("FAIL done_bus: we=%b addr=%h expected we=%b addr=%h",
                                 mem_we, mem_addr, e.we, e.addr);
                    end
                    if (e.we) begin
                        checks++;
                        if (mem_wdata !== e.wdata) begin
                            errors++;
                            $display("FAIL done_wdata: got %h expected %h", mem_wdata, e.wdata);
                        end
                    end
                    checks++;
                    if (req_cnt != e.waits || frz_cnt != e.waits + 1) begin
                        errors++;
                        $display("FAIL done_latency: req=%0d freeze=%0d expected req=%0d freeze=%0d",
                                 req_cnt, frz_cnt, e.waits, e.waits + 1);
                    end
                    checks++;
                    if (freeze !== 1'b0 || WB_EN_OUT !== e.wb || MEM_R_EN_OUT !== e.rout) begin
                        errors++;
                        $display("FAIL done_release: freeze=%b wb=%b rout=%b expected 0/%b/%b",
                                 freeze, WB_EN_OUT, MEM_R_EN_OUT, e.wb, e.rout);
                    end
                end
                frz_cnt = 0;
                req_cnt = 0;
            end
            prev_req = mem_req;
        end
    end

    // Drives one memory instruction and plays the bus; ack_after=0 means never ack.
    task automatic do_access(input logic r, input logic w, input logic wb,
                             input logic [W-1:0] addr, input logic [W-1:0] wdata,
                             input logic [RW-1:0] dst, input int ack_after,
                             input logic [W-1:0] rdata);
        exp_t e;
        int   n;
        int   guard;
        bit   done;
        e.we    = w;
        e.addr  = addr;
        e.wdata = wdata;
        e.wb    = wb;
        e.rout  = r;
        if (r && w) m_err = 1'b1;
        if (ack_after > 0 && ack_after <= TIMEOUT) begin
            e.waits = ack_after;
            if (!w) m_rval = rdata;
        end else begin
            e.waits = TIMEOUT;
            m_rval  = '0;
            m_err   = 1'b1;
        end
        e.rval = m_rval;
        e.err  = m_err;
        sb_q.push_back(e);

        WB_EN = wb; MEM_R_EN = r; MEM_W_EN = w;
        ALURes = addr; STVal = wdata; dest = dst;
        n = 0; guard = 0; done = 0;
        while (!done && guard < 64) begin
            @(posedge clk); #1;
            guard++;
            mem_ack   = 1'b0;
            mem_rdata = 16'hDEAD;
            if (!freeze) begin
                done = 1;
            end else if (mem_req) begin
                n++;
                if (n == ack_after) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_hang: freeze still %b after %0d cycles", freeze, guard);
        end
        @(posedge clk); #1;
        WB_EN = 0; MEM_R_EN = 0; MEM_W_EN = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        WB_EN = 0; MEM_R_EN = 0; MEM_W_EN = 0;
        ALURes = '0; STVal = '0; dest = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
            memReadVal !== '0 || mem_err !== 1'b0 || freeze !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h rval=%h err=%b frz=%b expected all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, memReadVal, mem_err, freeze);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_passthrough();
        WB_EN = 1; MEM_R_EN = 0; MEM_W_EN = 0;
        ALURes = 16'h0042; dest = 4'd3; STVal = 16'h7777;
        #1;
        checks++;
        if (freeze !== 1'b0 || WB_EN_OUT !== 1'b1 || MEM_R_EN_OUT !== 1'b0 ||
            ALUResOut !== 16'h0042 || destOut !== 4'd3) begin
            errors++;
            $display("FAIL alu_pass: frz=%b wb=%b rout=%b alu=%h dest=%h expected 0/1/0/0042/3",
                     freeze, WB_EN_OUT, MEM_R_EN_OUT, ALUResOut, destOut);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (mem_req !== 1'b0 || freeze !== 1'b0) begin
                errors++;
                $display("FAIL alu_noreq: req=%b frz=%b expected 0/0", mem_req, freeze);
            end
        end
        WB_EN = 0;
    endtask

    task automatic test_load();
        do_access(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 4'd5, 3, 16'hBEEF);
    endtask

    task automatic test_store();
        do_access(1'b0, 1'b1, 1'b0, 16'h0020, 16'h1234, 4'd0, 1, 16'h0BAD);
    endtask

    task automatic test_ack_on_last_cycle();
        do_access(1'b1, 1'b0, 1'b1, 16'h0044, 16'h0000, 4'd6, TIMEOUT, 16'hC0DE);
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000, 4'd1, 2, 16'h1111);
        do_access(1'b1, 1'b0, 1'b1, 16'h0102, 16'h0000, 4'd2, 1, 16'h2222);
    endtask

    task automatic test_timeout();
        do_access(1'b1, 1'b0, 1'b1, 16'h0200, 16'h0000, 4'd4, 0, 16'h9999);
    endtask

    task automatic test_reset_mid_wait();
        WB_EN = 1; MEM_R_EN = 1; MEM_W_EN = 0;
        ALURes = 16'h0300; STVal = 16'h4321; dest = 4'd7;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
            memReadVal !== '0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_regs: req=%b we=%b addr=%h wdata=%h rval=%h err=%b expected all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, memReadVal, mem_err);
        end
        checks++;
        if (freeze !== 1'b1 || ALUResOut !== 16'h0300) begin
            errors++;
            $display("FAIL rst_wait_comb: frz=%b alu=%h expected 1/0300", freeze, ALUResOut);
        end
        m_rval = '0;
        m_err  = 1'b0;
        @(posedge clk); #1;
        WB_EN = 0; MEM_R_EN = 0;
        rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b0 || memReadVal !== '0 || mem_err !== 1'b0 || freeze !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: req=%b rval=%h err=%b frz=%b expected 0/0000/0/0",
                     mem_req, memReadVal, mem_err, freeze);
        end
        do_access(1'b1, 1'b0, 1'b1, 16'h0310, 16'h0000, 4'd8, 2, 16'hA5A5);
    endtask

    task automatic test_rw_conflict();
        do_access(1'b1, 1'b1, 1'b1, 16'h0030, 16'h5555, 4'd9, 2, 16'h6666);
    endtask

    initial begin
        test_reset();
        test_alu_passthrough();
        test_load();
        test_store();
        test_ack_on_last_cycle();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        test_rw_conflict();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expectations never completed, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
